// File: rtl/icache_responder_if.sv
// Purpose : bundles the fetch-side request/response, translation and refill
//           signals of icache_responder. Suffix _i/_o is from the responder's view.
// Ports   : slave = responder side, master = fetch/TLB/memory side.
interface icache_responder_if;
  // request side
  logic         req_valid_i;
  logic [11:0]  req_idx_i;
  logic         req_kill_i;
  logic         invalidate_i;
  logic         tlb_req_valid_i;
  logic [27:0]  tlb_vpn_i;
  // response side
  logic         req_ready_o;
  logic         resp_valid_o;
  logic [127:0] resp_datablock_o;
  logic [39:0]  resp_vaddr_o;
  logic         resp_ready_i;
  // translation
  logic         tlb_resp_miss_o;
  logic         tlb_resp_xcpt_if_o;
  logic         iptw_resp_valid_o;
  // refill
  logic         mem_req_valid_o;
  logic [35:0]  mem_req_addr_o;
  logic         mem_req_ready_i;
  logic         mem_resp_valid_i;
  logic [127:0] mem_resp_data_i;

  modport slave (
    input  req_valid_i, req_idx_i, req_kill_i, invalidate_i, tlb_req_valid_i, tlb_vpn_i,
    input  resp_ready_i, mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
    output req_ready_o, resp_valid_o, resp_datablock_o, resp_vaddr_o,
    output tlb_resp_miss_o, tlb_resp_xcpt_if_o, iptw_resp_valid_o,
    output mem_req_valid_o, mem_req_addr_o
  );

  modport master (
    output req_valid_i, req_idx_i, req_kill_i, invalidate_i, tlb_req_valid_i, tlb_vpn_i,
    output resp_ready_i, mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
    input  req_ready_o, resp_valid_o, resp_datablock_o, resp_vaddr_o,
    input  tlb_resp_miss_o, tlb_resp_xcpt_if_o, iptw_resp_valid_o,
    input  mem_req_valid_o, mem_req_addr_o
  );
endinterface

// File: rtl/icache_responder.sv
// Purpose : direct-mapped 8x128b instruction cache with a one-entry identity uTLB
//           and a single-request lookup/walk/refill/respond FSM.
// Latency : hit response 2 cycles after acceptance; refill response 1 cycle after mem_resp_valid_i.
// Backpr. : one request in flight (req_ready_o only in IDLE); mem_req and resp held until ready.
// Ports   : clk_i, rst_i (async, active-high); bus = icache_responder_if.slave.
module icache_responder (
  input  logic              clk_i,
  input  logic              rst_i,
  icache_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, PTW, REFILL_REQ, REFILL_WAIT, RESP
  } state_t;

  state_t       r_state;
  logic [7:0]   r_line_addr;      // vaddr[11:4] of the captured request
  logic [27:0]  r_vpn;            // vpn sampled in LOOKUP
  logic         r_kill;           // kill seen during refill
  logic [7:0]   r_line_vld;
  logic [32:0]  r_tag  [8];
  logic [127:0] r_data [8];
  logic [27:0]  r_utlb_vpn;
  logic         r_utlb_vld;

  logic         r_req_ready;
  logic         r_resp_valid;
  logic [127:0] r_resp_data;
  logic [39:0]  r_resp_vaddr;
  logic         r_mem_req_valid;
  logic [35:0]  r_mem_req_addr;
  logic         r_iptw;

  logic [2:0]   w_line;
  logic         w_in_lookup;
  logic         w_abort;
  logic         w_xcpt;
  logic         w_tlb_miss;
  logic         w_hit;
  logic         w_fill;
  logic         w_unused_offset;

  assign w_line      = r_line_addr[2:0];
  assign w_in_lookup = (r_state == LOOKUP);
  assign w_abort     = bus.req_kill_i || !bus.tlb_req_valid_i;
  // Translation results are combinational so they land in the LOOKUP cycle itself.
  assign w_xcpt      = w_in_lookup && !w_abort && bus.tlb_vpn_i[27];
  assign w_tlb_miss  = w_in_lookup && !w_abort && !bus.tlb_vpn_i[27] &&
                       !(r_utlb_vld && (r_utlb_vpn == bus.tlb_vpn_i));
  assign w_hit       = r_line_vld[w_line] && (r_tag[w_line] == {bus.tlb_vpn_i, r_line_addr[7:3]});
  assign w_fill      = (r_state == REFILL_WAIT) && bus.mem_resp_valid_i;
  // Byte offset within a line never affects a fetch of the whole line.
  assign w_unused_offset = &{1'b0, bus.req_idx_i[3:0]};

  // Line storage needs no reset: the valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (w_fill) begin
      r_data[w_line] <= bus.mem_resp_data_i;
      r_tag[w_line]  <= {r_vpn, r_line_addr[7:3]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state         <= IDLE;
      r_line_addr     <= '0;
      r_vpn           <= '0;
      r_kill          <= 1'b0;
      r_line_vld      <= '0;
      r_utlb_vpn      <= '0;
      r_utlb_vld      <= 1'b0;
      r_req_ready     <= 1'b1;
      r_resp_valid    <= 1'b0;
      r_resp_data     <= '0;
      r_resp_vaddr    <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_iptw          <= 1'b0;
    end else begin
      r_iptw <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid_i) begin
            r_line_addr <= bus.req_idx_i[11:4];
            r_req_ready <= 1'b0;
            r_state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_vpn <= bus.tlb_vpn_i;
          if (w_abort || bus.tlb_vpn_i[27]) begin
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end else if (w_tlb_miss) begin
            r_iptw  <= 1'b1;             // high for exactly the PTW cycle
            r_state <= PTW;
          end else if (w_hit) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= r_data[w_line];
            r_resp_vaddr <= {bus.tlb_vpn_i, r_line_addr, 4'h0};
            r_state      <= RESP;
          end else begin
            r_kill          <= 1'b0;
            r_mem_req_valid <= 1'b1;
            r_mem_req_addr  <= {bus.tlb_vpn_i, r_line_addr};
            r_state         <= REFILL_REQ;
          end
        end
        PTW: begin
          r_utlb_vpn  <= r_vpn;
          r_utlb_vld  <= 1'b1;
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
        REFILL_REQ: begin
          if (bus.req_kill_i) r_kill <= 1'b1;
          if (bus.mem_req_ready_i) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= REFILL_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (w_fill) begin
            r_line_vld[w_line] <= 1'b1;
            // A killed refill still fills the line, it just answers nobody.
            if (r_kill || bus.req_kill_i) begin
              r_req_ready <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_data  <= bus.mem_resp_data_i;
              r_resp_vaddr <= {r_vpn, r_line_addr, 4'h0};
              r_state      <= RESP;
            end
          end else if (bus.req_kill_i) begin
            r_kill <= 1'b1;
          end
        end
        RESP: begin
          if (bus.req_kill_i || bus.resp_ready_i) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
      // Last assignment wins, so invalidate overrides a same-cycle line fill or uTLB load.
      if (bus.invalidate_i) begin
        r_line_vld <= '0;
        r_utlb_vld <= 1'b0;
      end
    end
  end

  assign bus.req_ready_o        = r_req_ready;
  assign bus.resp_valid_o       = r_resp_valid;
  assign bus.resp_datablock_o   = r_resp_data;
  assign bus.resp_vaddr_o       = r_resp_vaddr;
  assign bus.tlb_resp_miss_o    = w_tlb_miss;
  assign bus.tlb_resp_xcpt_if_o = w_xcpt;
  assign bus.iptw_resp_valid_o  = r_iptw;
  assign bus.mem_req_valid_o    = r_mem_req_valid;
  assign bus.mem_req_addr_o     = r_mem_req_addr;

endmodule

// File: tb/tb_icache_responder.sv
// Purpose : directed bench for icache_responder; responses are checked by a
//           scoreboard monitor, per-cycle control outputs by the stimulus thread.
module tb_icache_responder;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  icache_responder_if bus();

  icache_responder dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [127:0] data;
    logic [39:0]  vaddr;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [127:0] D1 = 128'h008040130050001300003013fff02013;
  localparam logic [127:0] D2 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] D3 = 128'hdeadbeef00c0ffee5555aaaa12345678;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: sample half a cycle away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #1;
      chk("resp_and_memreq", bus.resp_valid_o & bus.mem_req_valid_o, 0);
      chk("pulses_onehot0", $onehot0({bus.tlb_resp_miss_o, bus.tlb_resp_xcpt_if_o,
                                      bus.iptw_resp_valid_o}), 1);
      if (!rst_i && bus.resp_valid_o && bus.resp_ready_i) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_resp: got vaddr %0h, none expected (t=%0t)",
                   bus.resp_vaddr_o, $time);
        end else begin
          e = exp_q.pop_front();
          chk("resp_datablock", bus.resp_datablock_o, e.data);
          chk("resp_vaddr", bus.resp_vaddr_o, e.vaddr);
        end
      end
    end
  end

  // Present a request in IDLE; returns #1 into the LOOKUP cycle with the
  // translation inputs still driven.
  task automatic start_req(input logic [11:0] idx, input logic [27:0] vpn);
    @(negedge clk_i);
    bus.req_valid_i     = 1'b1;
    bus.req_idx_i       = idx;
    bus.tlb_req_valid_i = 1'b1;
    bus.tlb_vpn_i       = vpn;
    #1 chk("req_ready_idle", bus.req_ready_o, 1);
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    #1;
  endtask

  task automatic tlb_walk(input logic [11:0] idx, input logic [27:0] vpn);
    start_req(idx, vpn);
    chk("walk_miss_pulse", bus.tlb_resp_miss_o, 1);
    chk("walk_no_xcpt", bus.tlb_resp_xcpt_if_o, 0);
    chk("walk_iptw_not_yet", bus.iptw_resp_valid_o, 0);
    @(negedge clk_i);
    bus.tlb_req_valid_i = 1'b0;
    #1 chk("walk_iptw_pulse", bus.iptw_resp_valid_o, 1);
    chk("walk_miss_dropped", bus.tlb_resp_miss_o, 0);
    @(negedge clk_i);
    #1 chk("walk_iptw_dropped", bus.iptw_resp_valid_o, 0);
    chk("walk_back_idle", bus.req_ready_o, 1);
    chk("walk_no_resp", bus.resp_valid_o, 0);
  endtask

  task automatic do_refill(input logic [11:0] idx, input logic [27:0] vpn,
                           input logic [35:0] addr, input logic [127:0] data,
                           input logic [39:0] vaddr, input bit kill);
    exp_t e;
    start_req(idx, vpn);
    chk("refill_no_miss", bus.tlb_resp_miss_o, 0);
    chk("refill_lookup_no_resp", bus.resp_valid_o, 0);
    if (!kill) begin
      e.data  = data;
      e.vaddr = vaddr;
      exp_q.push_back(e);
    end
    @(negedge clk_i);
    bus.tlb_req_valid_i = 1'b0;
    bus.mem_req_ready_i = 1'b0;
    #1 chk("mem_req_valid", bus.mem_req_valid_o, 1);
    chk("mem_req_addr", bus.mem_req_addr_o, addr);
    @(negedge clk_i);
    bus.mem_req_ready_i = 1'b1;
    #1 chk("mem_req_held", bus.mem_req_valid_o, 1);
    chk("mem_req_addr_stable", bus.mem_req_addr_o, addr);
    @(negedge clk_i);
    bus.req_kill_i = kill;
    #1 chk("mem_req_dropped", bus.mem_req_valid_o, 0);
    @(negedge clk_i);
    bus.req_kill_i       = 1'b0;
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_resp_data_i  = data;
    @(negedge clk_i);
    bus.mem_resp_valid_i = 1'b0;
    bus.mem_resp_data_i  = '0;
    #1 chk("refill_resp_valid", bus.resp_valid_o, !kill);
    chk("refill_req_ready", bus.req_ready_o, kill);
    @(negedge clk_i);
    #1 chk("refill_done_idle", bus.req_ready_o, 1);
    chk("refill_resp_cleared", bus.resp_valid_o, 0);
  endtask

  // Hit path; with ready=0 it returns #1 into the RESP cycle.
  task automatic do_hit(input logic [11:0] idx, input logic [27:0] vpn,
                        input logic [127:0] data, input logic [39:0] vaddr, input bit ready);
    exp_t e;
    bus.resp_ready_i = ready;
    if (ready) begin
      e.data  = data;
      e.vaddr = vaddr;
      exp_q.push_back(e);
    end
    start_req(idx, vpn);
    chk("hit_no_miss", bus.tlb_resp_miss_o, 0);
    chk("hit_lookup_no_resp", bus.resp_valid_o, 0);
    @(negedge clk_i);
    bus.tlb_req_valid_i = 1'b0;
    #1 chk("hit_resp_at_2", bus.resp_valid_o, 1);
    chk("hit_no_mem_req", bus.mem_req_valid_o, 0);
    chk("hit_not_ready", bus.req_ready_o, 0);
    if (ready) begin
      @(negedge clk_i);
      #1 chk("hit_done_idle", bus.req_ready_o, 1);
      chk("hit_resp_cleared", bus.resp_valid_o, 0);
    end
  endtask

  initial begin
    bus.req_valid_i      = 1'b0;
    bus.req_idx_i        = '0;
    bus.req_kill_i       = 1'b0;
    bus.invalidate_i     = 1'b0;
    bus.tlb_req_valid_i  = 1'b0;
    bus.tlb_vpn_i        = '0;
    bus.resp_ready_i     = 1'b1;
    bus.mem_req_ready_i  = 1'b1;
    bus.mem_resp_valid_i = 1'b0;
    bus.mem_resp_data_i  = '0;

    // Reset values
    #2 rst_i = 1'b1;
    @(negedge clk_i);
    #1 chk("rst_req_ready", bus.req_ready_o, 1);
    chk("rst_resp_valid", bus.resp_valid_o, 0);
    chk("rst_datablock", bus.resp_datablock_o, 0);
    chk("rst_vaddr", bus.resp_vaddr_o, 0);
    chk("rst_mem_req_valid", bus.mem_req_valid_o, 0);
    chk("rst_mem_req_addr", bus.mem_req_addr_o, 0);
    chk("rst_iptw", bus.iptw_resp_valid_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // uTLB miss and walk for vaddr 0x2000
    tlb_walk(12'h000, 28'h0000002);
    // Refill of vaddr 0x2000
    do_refill(12'h000, 28'h0000002, 36'h000000200, D1, 40'h0000002000, 1'b0);
    // Hit on vaddr 0x2004, same line
    do_hit(12'h004, 28'h0000002, D1, 40'h0000002000, 1'b1);

    // Fetch exception
    start_req(12'h000, 28'h8000000);
    chk("xcpt_pulse", bus.tlb_resp_xcpt_if_o, 1);
    chk("xcpt_no_miss", bus.tlb_resp_miss_o, 0);
    @(negedge clk_i);
    bus.tlb_req_valid_i = 1'b0;
    #1 chk("xcpt_dropped", bus.tlb_resp_xcpt_if_o, 0);
    chk("xcpt_no_mem_req", bus.mem_req_valid_o, 0);
    chk("xcpt_idle", bus.req_ready_o, 1);
    chk("xcpt_no_iptw", bus.iptw_resp_valid_o, 0);

    // Killed refill of 0x2010 still fills the line
    do_refill(12'h010, 28'h0000002, 36'h000000201, D2, 40'h0000002010, 1'b1);
    do_hit(12'h010, 28'h0000002, D2, 40'h0000002010, 1'b1);

    // Kill while a response is waiting on resp_ready
    do_hit(12'h018, 28'h0000002, D2, 40'h0000002010, 1'b0);
    @(negedge clk_i);
    #1 chk("resp_held", bus.resp_valid_o, 1);
    chk("resp_held_data", bus.resp_datablock_o, D2);
    @(negedge clk_i);
    bus.req_kill_i = 1'b1;
    @(negedge clk_i);
    bus.req_kill_i   = 1'b0;
    bus.resp_ready_i = 1'b1;
    #1 chk("resp_kill_dropped", bus.resp_valid_o, 0);
    chk("resp_kill_idle", bus.req_ready_o, 1);

    // Invalidate clears uTLB and lines
    @(negedge clk_i);
    bus.invalidate_i = 1'b1;
    @(negedge clk_i);
    bus.invalidate_i = 1'b0;
    tlb_walk(12'h000, 28'h0000002);
    do_refill(12'h000, 28'h0000002, 36'h000000200, D3, 40'h0000002000, 1'b0);

    // Reset in the middle of a refill
    start_req(12'h020, 28'h0000002);
    chk("rstmid_no_miss", bus.tlb_resp_miss_o, 0);
    @(negedge clk_i);
    bus.tlb_req_valid_i = 1'b0;
    #1 chk("rstmid_mem_req", bus.mem_req_addr_o, 36'h000000202);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1 chk("rstmid_mem_req_cleared", bus.mem_req_valid_o, 0);
    chk("rstmid_req_ready", bus.req_ready_o, 1);
    @(negedge clk_i);
    rst_i                = 1'b0;
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_resp_data_i  = D2;
    @(negedge clk_i);
    bus.mem_resp_valid_i = 1'b0;
    #1 chk("rstmid_stray_resp_ignored", bus.resp_valid_o, 0);
    chk("rstmid_still_idle", bus.req_ready_o, 1);
    tlb_walk(12'h020, 28'h0000002);
    do_refill(12'h020, 28'h0000002, 36'h000000202, D1, 40'h0000002020, 1'b0);

    @(negedge clk_i);
    #2 chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high: clk_i  in  1  clock, all state on rising edge; rst_i  in  1  async active-high reset.
REQ-002 SHALL have these request-side ports, driven by the fetch-side cache interface:
- req_valid_i  in  1  lookup request;
- req_idx_i  in  12  vaddr[11:0];
- req_kill_i  in  1  abort the in-flight request;
- invalidate_i  in  1  flush the cache;
- tlb_req_valid_i  in  1  translation valid;
- tlb_vpn_i  in  28  vaddr[39:12].
REQ-003 SHALL have these response-side ports:
- req_ready_o  out  1  can accept a request;
- resp_valid_o  out  1  response valid;
- resp_datablock_o  out  128  fetched line;
- resp_vaddr_o  out  40  vaddr of the line, {vpn,idx[11:4],4'b0};
- resp_ready_i  in  1  consumer accepts the response.
REQ-004 SHALL have these translation ports: tlb_resp_miss_o  out  1  uTLB miss pulse; tlb_resp_xcpt_if_o  out  1  fetch exception pulse; iptw_resp_valid_o  out  1  walk-done pulse.
REQ-005 SHALL have these refill ports: mem_req_valid_o  out  1; mem_req_addr_o  out  36  line address vaddr[39:4]; mem_req_ready_i  in  1; mem_resp_valid_i  in  1; mem_resp_data_i  in  128.

Function
REQ-006 SHALL implement a direct-mapped cache of 8 lines x 128 bits: index vaddr[6:4], tag vaddr[39:7], one valid bit per line.
REQ-007 SHALL implement a single-entry micro-TLB holding a vpn and a valid bit; translation is identity.
REQ-008 SHALL use the FSM states IDLE, LOOKUP, PTW, REFILL_REQ, REFILL_WAIT, RESP.
REQ-009 SHALL assert req_ready_o only in IDLE; req_valid_i && req_ready_o captures req_idx_i, then IDLE->LOOKUP.
REQ-010 In LOOKUP, SHALL sample tlb_req_valid_i and tlb_vpn_i and apply the first matching rule, in this order:
- req_kill_i=1 or tlb_req_valid_i=0 -> IDLE, no outputs;
- tlb_vpn_i[27]=1 -> tlb_resp_xcpt_if_o=1 (combinational, this cycle) -> IDLE;
- uTLB miss -> tlb_resp_miss_o=1 this cycle -> PTW;
- tag hit -> RESP;
- tag miss -> REFILL_REQ.
REQ-011 In PTW (exactly 1 cycle), SHALL load the uTLB with the captured vpn, set its valid bit, pulse iptw_resp_valid_o=1, then go to IDLE; it issues no response, and the requester re-issues the request.
REQ-012 In REFILL_REQ, SHALL hold mem_req_valid_o=1 with a stable mem_req_addr_o until mem_req_ready_i=1, then go to REFILL_WAIT.
REQ-013 In REFILL_WAIT, on mem_resp_valid_i SHALL write mem_resp_data_i, the tag and valid=1 into the indexed line, then go to RESP (or to IDLE if killed, per REQ-015).
REQ-014 In RESP, SHALL drive resp_valid_o=1 with registered datablock/vaddr, held stable until resp_ready_i=1; the handshake cycle returns to IDLE.
- RESP entered from LOOKUP: resp_valid_o rises 1 cycle after LOOKUP (hit latency = 2 cycles from request acceptance).
- RESP entered from REFILL_WAIT: resp_valid_o rises 1 cycle after mem_resp_valid_i.
REQ-015 SHALL latch req_kill_i asserted in REFILL_REQ or REFILL_WAIT; the refill then completes and the line is written, but the FSM goes to IDLE with no response.
REQ-016 req_kill_i in RESP SHALL drop resp_valid_o the next cycle and return to IDLE.
REQ-017 invalidate_i SHALL clear all line valid bits and the uTLB valid in that cycle in any state, without changing FSM state.
- If concurrent with a refill line write, invalidate wins and the line is left invalid.
- A response already in RESP still completes.
REQ-018 tlb_resp_miss_o, tlb_resp_xcpt_if_o and iptw_resp_valid_o SHALL each be single-cycle pulses and are never asserted together.
REQ-019 SHALL never assert mem_req_valid_o and resp_valid_o in the same cycle.

Reset
REQ-020 rst_i SHALL asynchronously force:
- FSM to IDLE;
- all line valids and the uTLB valid to 0;
- req_ready_o=1;
- all other outputs to 0, including the 0 datablock/vaddr/addr buses.
REQ-021 Reset mid-refill SHALL abandon the refill; the line is not written, and a later mem_resp_valid_i in IDLE is ignored.

Verification
REQ-022 Reset, then idx=0x000 and vpn=0x0000002 (vaddr 0x2000) -> tlb_resp_miss_o in LOOKUP, iptw_resp_valid_o next cycle, no resp_valid_o.
REQ-023 Re-issue vaddr 0x2000 -> mem_req_addr_o=0x000000200; mem_resp_data_i=0x008040130050001300003013fff02013 -> resp_valid_o with that datablock and resp_vaddr_o=0x0000002000.
REQ-024 Request vaddr 0x2004 with resp_ready_i=1 -> hit, resp_valid_o 2 cycles after acceptance, same datablock, resp_vaddr_o=0x0000002000, no mem_req_valid_o.
REQ-025 vpn=0x8000000 -> tlb_resp_xcpt_if_o=1 for one cycle; no refill, no response.
REQ-026 Kill during REFILL_WAIT on vaddr 0x2010 -> no resp_valid_o; a re-request of 0x2010 hits.
REQ-027 Assert invalidate_i, then request 0x2000 -> tlb_resp_miss_o (uTLB cleared); after the walk, the re-request refills again.
